// File: rtl/pc_generator.sv
// Program counter generator: issues one {epoch, pc} fetch beat per handshake and
// applies writeback redirects, bumping the epoch and pulsing flush on each one.
module pc_generator #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned     EPOCH_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wbpcg_tvalid,
    output logic                    wbpcg_tready,
    input  logic [XLEN-1:0]         wbpcg_tdata,
    output logic                    pcgif_tvalid,
    input  logic                    pcgif_tready,
    output logic [EPOCH_W+XLEN-1:0] pcgif_tdata,
    output logic                    flush
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e              state_q, state_d;
    logic                vld_q, vld_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [EPOCH_W-1:0]  tag_q, tag_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic                pend_vld_q, pend_vld_d;
    logic [XLEN-1:0]     pend_pc_q, pend_pc_d;
    logic                flush_q, flush_d;

    logic                slot_free;
    logic                redir_hs;
    logic                out_hs;
    logic [XLEN-1:0]     target;
    logic [EPOCH_W-1:0]  epoch_inc;

    // Redirect targets are word aligned, the low bits are dropped.
    logic unused_tdata_lsb;
    assign unused_tdata_lsb = ^wbpcg_tdata[1:0];

    assign target       = {wbpcg_tdata[XLEN-1:2], 2'b00};
    assign epoch_inc    = epoch_q + EPOCH_W'(1);
    assign slot_free    = !vld_q || pcgif_tready;
    assign wbpcg_tready = (state_q == StRun) && !pend_vld_q;
    assign redir_hs     = wbpcg_tvalid && wbpcg_tready;
    assign out_hs       = vld_q && pcgif_tready;

    assign pcgif_tvalid = vld_q;
    assign pcgif_tdata  = {tag_q, pc_q};
    assign flush        = flush_q;

    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        epoch_d    = epoch_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        flush_d    = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StRun;
                vld_d   = 1'b1;
            end
            StRun: begin
                if (redir_hs) begin
                    epoch_d = epoch_inc;
                    flush_d = 1'b1;
                    if (slot_free) begin
                        // Bypass: the target replaces pc+4 in the same cycle.
                        vld_d = 1'b1;
                        pc_d  = target;
                        tag_d = epoch_inc;
                    end else begin
                        pend_vld_d = 1'b1;
                        pend_pc_d  = target;
                    end
                end else if (out_hs) begin
                    vld_d = 1'b1;
                    tag_d = epoch_q;
                    if (pend_vld_q) begin
                        pc_d       = pend_pc_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StBoot;
            vld_q      <= 1'b0;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            epoch_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            epoch_q    <= epoch_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
            flush_q    <= flush_d;
        end
    end

endmodule

// File: tb/tb_pc_generator.sv
// Bench for pc_generator: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_pc_generator;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wv = 1'b0;
    logic [31:0] wd = '0;
    logic        pr = 1'b0;
    logic        wr, pv, fl;
    logic [33:0] pd;

    int checks = 0;
    int passes = 0;

    pc_generator #(.XLEN(32), .RESET_PC(RST_PC), .EPOCH_W(2)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .wbpcg_tvalid (wv),
        .wbpcg_tready (wr),
        .wbpcg_tdata  (wd),
        .pcgif_tvalid (pv),
        .pcgif_tready (pr),
        .pcgif_tdata  (pd),
        .flush        (fl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, required %h at %0t", name, got, exp, $time);
    endtask

    // Transaction-level model: current beat, epoch counter and a one-deep redirect queue.
    bit          m_run, m_vld, m_flush, m_acc, m_take;
    int unsigned m_epoch, m_bepoch;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_vld = 0; m_flush = 0; m_epoch = 0; m_bepoch = 0; m_pc = RST_PC;
            m_pend.delete();
        end else if (!m_run) begin
            m_run = 1; m_vld = 1; m_flush = 0;
        end else begin
            m_acc   = wv && (m_pend.size() == 0);
            m_take  = m_vld && pr;
            m_flush = m_acc;
            if (m_acc) begin
                m_epoch = (m_epoch + 1) % 4;
                if (m_take || !m_vld) begin
                    m_pc = wd & ~32'h3; m_bepoch = m_epoch; m_vld = 1;
                end else begin
                    m_pend.push_back(wd & ~32'h3);
                end
            end else if (m_take) begin
                m_bepoch = m_epoch;
                if (m_pend.size() != 0) m_pc = m_pend.pop_front();
                else m_pc = m_pc + 32'd4;
            end
        end
    end

    logic [1:0] m_tag;
    always @(negedge clk) begin
        m_tag = m_bepoch[1:0];
        chk("tvalid", 64'(pv), 64'(m_vld));
        chk("wbpcg_tready", 64'(wr), 64'(m_run && m_pend.size() == 0));
        chk("flush", 64'(fl), 64'(m_flush));
        chk("tdata", 64'(pd), 64'({m_tag, m_pc}));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        pr = 1'b1;
        step(); step();
        rst_n = 1'b1;
        // T1: first beat one cycle after release, then +4 per cycle
        chk("t1_pre_valid", 64'(pv), 64'd0);
        step(); chk("t1_valid", 64'(pv), 64'd1); chk("t1_b0", 64'(pd), 64'h0_8000_0000);
        step(); chk("t1_b1", 64'(pd), 64'h0_8000_0004);
        step(); chk("t1_b2", 64'(pd), 64'h0_8000_0008);
        // T2: bypass redirect
        wv = 1'b1; wd = 32'h8000_0100;
        chk("t2_ready", 64'(wr), 64'd1);
        step(); wv = 1'b0;
        chk("t2_beat", 64'(pd), 64'h1_8000_0100); chk("t2_flush", 64'(fl), 64'd1);
        step(); chk("t2_next", 64'(pd), 64'h1_8000_0104); chk("t2_flush_end", 64'(fl), 64'd0);
        // T3/T4: stalled beat, pending redirect, second redirect held off
        pr = 1'b0;
        step(); chk("t3_hold", 64'(pd), 64'h1_8000_0104);
        wv = 1'b1; wd = 32'h0000_0200;
        step(); chk("t3_stale", 64'(pd), 64'h1_8000_0104);
        chk("t3_ready_low", 64'(wr), 64'd0); chk("t3_flush", 64'(fl), 64'd1);
        wd = 32'h0000_0400;
        step(); chk("t4_held_off", 64'(fl), 64'd0); chk("t4_stable", 64'(pd), 64'h1_8000_0104);
        pr = 1'b1;
        step(); chk("t4_first", 64'(pd), 64'h2_0000_0200);
        step(); chk("t4_second", 64'(pd), 64'h3_0000_0400); chk("t4_flush2", 64'(fl), 64'd1);
        wd = 32'hFFFF_FFFE;
        // T5: alignment, pc wrap and epoch 3 -> 0 wrap
        step(); wv = 1'b0; chk("t5_align", 64'(pd), 64'h0_FFFF_FFFC);
        step(); chk("t5_wrap", 64'(pd), 64'h0_0000_0000);
        // T6: async reset with a redirect pending
        pr = 1'b0; wv = 1'b1; wd = 32'h0000_0500;
        step(); wv = 1'b0; chk("t6_pending", 64'(wr), 64'd0);
        #1 rst_n = 1'b0;
        #1 chk("t6_async_valid", 64'(pv), 64'd0); chk("t6_tdata", 64'(pd), 64'h0_8000_0000);
        step(); rst_n = 1'b1; pr = 1'b1;
        step(); chk("t6_restart", 64'(pd), 64'h0_8000_0000);
        chk("t6_valid", 64'(pv), 64'd1); chk("t6_no_flush", 64'(fl), 64'd0);
        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step();
            pr = ($urandom % 4) != 0;
            wv = ($urandom % 3) == 0;
            wd = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
            if ($urandom % 400 == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        wv = 1'b0;
        step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
